// File: rtl/coin_pkg.sv
// coin_pkg: shared coin encoding and output-FSM state type for the coin input conditioner
package coin_pkg;
  localparam logic COIN_HALF   = 1'b0;
  localparam logic COIN_DOLLAR = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: synchronizes one raw coin sensor, debounces it and flags each debounced rising edge
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw asynchronous sensor level
//   rise_evt   : 1-cycle registered pulse on each debounced 0->1 flip
module coin_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise_evt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic level, differ, flip;
  always_comb begin
    differ = sync[SYNC_STAGES-1] != level;
    flip   = differ && cnt == CW'(DEBOUNCE_CYCLES - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync     <= '0;
      cnt      <= '0;
      level    <= 1'b0;
      rise_evt <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], raw};
      cnt      <= (differ && !flip) ? cnt + CW'(1) : '0;
      level    <= flip ? ~level : level;
      rise_evt <= flip & ~level;
    end
endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: turns bouncy coin sensors into queued, spaced 1-cycle coin pulses
//   clk, rst_n                     : clock, asynchronous active-low reset
//   coin_dollar_raw, coin_half_raw : raw asynchronous sensor levels
//   accept_en                      : 1 = new coins accepted, 0 = new coins rejected
//   one_dollar, half_dollar        : 1-cycle pulse per accepted coin, never both at once
//   coin_reject                    : 1-cycle pulse per refused or dropped coin
//   overflow                       : sticky, a coin was dropped on a full queue
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin_dollar_raw,
  input  logic coin_half_raw,
  input  logic accept_en,
  output logic one_dollar,
  output logic half_dollar,
  output logic coin_reject,
  output logic overflow
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int PW = AW + 1;
  logic rise_d, rise_h, pend;
  logic [AW:0] wp, rp;
  logic mem [QUEUE_DEPTH];
  state_t state, state_n;
  logic empty, full, push_req, push_data, reject, drop_full, push, pop;

  coin_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dollar (
    .clk(clk), .rst_n(rst_n), .raw(coin_dollar_raw), .rise_evt(rise_d)
  );
  coin_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_half (
    .clk(clk), .rst_n(rst_n), .raw(coin_half_raw), .rise_evt(rise_h)
  );

  // A pending half (from a simultaneous pair) is pushed one cycle after its dollar;
  // acceptance and fullness are judged in the cycle of the actual push, before any pop.
  always_comb begin
    empty     = wp == rp;
    full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    push_req  = pend | rise_d | rise_h;
    push_data = pend ? COIN_HALF : rise_d ? COIN_DOLLAR : COIN_HALF;
    reject    = push_req & (~accept_en | full);
    drop_full = push_req & accept_en & full;
    push      = push_req & ~reject;
    pop       = state == ST_IDLE && !empty;
    state_n   = pop ? ST_PULSE : state == ST_PULSE ? ST_GAP : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= ST_IDLE;
      wp          <= '0;
      rp          <= '0;
      pend        <= 1'b0;
      one_dollar  <= 1'b0;
      half_dollar <= 1'b0;
      coin_reject <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      wp          <= push ? wp + PW'(1) : wp;
      rp          <= pop ? rp + PW'(1) : rp;
      pend        <= rise_d & rise_h;
      one_dollar  <= pop & (mem[rp[AW-1:0]] == COIN_DOLLAR);
      half_dollar <= pop & (mem[rp[AW-1:0]] == COIN_HALF);
      coin_reject <= reject;
      overflow    <= overflow | drop_full;
    end

  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= push_data;
endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb_coin_input_conditioner: directed self-checking bench for coin_input_conditioner
module tb_coin_input_conditioner;
  logic clk = 1'b0, rst_n = 1'b0, accept_en = 1'b1;
  logic dollar_raw = 1'b0, half_raw = 1'b0, dollar_raw2 = 1'b0, half_raw2 = 1'b0;
  logic one_dollar, half_dollar, coin_reject, overflow;
  logic one_dollar2, half_dollar2, coin_reject2, overflow2;
  int cyc = 0, n_tests = 0, n_fail = 0;
  int n_d = 0, n_h = 0, n_r = 0, n_both = 0, t_d = 0, t_h = 0;
  int n_d2 = 0, n_h2 = 0, n_r2 = 0;
  int s_d, s_h, s_r, s_d2, s_h2, s_r2, t0;

  coin_input_conditioner dut (
    .clk(clk), .rst_n(rst_n), .coin_dollar_raw(dollar_raw), .coin_half_raw(half_raw),
    .accept_en(accept_en), .one_dollar(one_dollar), .half_dollar(half_dollar),
    .coin_reject(coin_reject), .overflow(overflow)
  );
  coin_input_conditioner #(.DEBOUNCE_CYCLES(2), .QUEUE_DEPTH(2)) dut_ovf (
    .clk(clk), .rst_n(rst_n), .coin_dollar_raw(dollar_raw2), .coin_half_raw(half_raw2),
    .accept_en(accept_en), .one_dollar(one_dollar2), .half_dollar(half_dollar2),
    .coin_reject(coin_reject2), .overflow(overflow2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n) begin
      if (one_dollar) begin n_d++; t_d = cyc; end
      if (half_dollar) begin n_h++; t_h = cyc; end
      if (coin_reject) n_r++;
      if (one_dollar && half_dollar) n_both++;
      if (one_dollar2 && half_dollar2) n_both++;
      if (one_dollar2) n_d2++;
      if (half_dollar2) n_h2++;
      if (coin_reject2) n_r2++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_d = n_d; s_h = n_h; s_r = n_r; s_d2 = n_d2; s_h2 = n_h2; s_r2 = n_r2;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_one_dollar", one_dollar, 0);
    chk("rst_half_dollar", half_dollar, 0);
    chk("rst_coin_reject", coin_reject, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    // T1 clean dollar
    snap(); t0 = cyc;
    dollar_raw = 1'b1; repeat (10) @(negedge clk);
    dollar_raw = 1'b0; repeat (12) @(negedge clk);
    chk("t1_dollar_cycles", n_d - s_d, 1);
    chk("t1_latency", t_d - t0, 8);
    chk("t1_reject", n_r - s_r, 0);
    chk("t1_half", n_h - s_h, 0);
    // T2 bounce then glitches
    snap();
    for (int i = 0; i < 4; i++) begin half_raw = (i % 2 == 0); @(negedge clk); end
    half_raw = 1'b1; repeat (10) @(negedge clk);
    half_raw = 1'b0; repeat (12) @(negedge clk);
    chk("t2_bounce_half", n_h - s_h, 1);
    snap();
    half_raw = 1'b1; repeat (3) @(negedge clk);
    half_raw = 1'b0; dollar_raw = 1'b1; repeat (2) @(negedge clk);
    dollar_raw = 1'b0; repeat (12) @(negedge clk);
    chk("t2_glitch_half", n_h - s_h, 0);
    chk("t2_glitch_dollar", n_d - s_d, 0);
    // T3 simultaneous coins
    snap(); t0 = cyc;
    dollar_raw = 1'b1; half_raw = 1'b1; repeat (10) @(negedge clk);
    dollar_raw = 1'b0; half_raw = 1'b0; repeat (15) @(negedge clk);
    chk("t3_dollar", n_d - s_d, 1);
    chk("t3_half", n_h - s_h, 1);
    chk("t3_dollar_latency", t_d - t0, 8);
    chk("t3_half_after_dollar", t_h - t_d, 3);
    chk("t3_reject", n_r - s_r, 0);
    // T4a six spaced dollars, all drained
    snap();
    for (int i = 0; i < 6; i++) begin
      dollar_raw = 1'b1; repeat (5) @(negedge clk);
      dollar_raw = 1'b0; repeat (5) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("t4_spaced_dollars", n_d - s_d, 6);
    chk("t4_spaced_reject", n_r - s_r, 0);
    chk("t4_spaced_overflow", overflow, 0);
    // T4b back-to-back pairs into a 2-deep queue with 2-cycle debounce
    snap();
    for (int i = 0; i < 6; i++) begin
      dollar_raw2 = 1'b1; half_raw2 = 1'b1; repeat (2) @(negedge clk);
      dollar_raw2 = 1'b0; half_raw2 = 1'b0; repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("t4_ovf_dollars", n_d2 - s_d2, 6);
    chk("t4_ovf_halves", n_h2 - s_h2, 3);
    chk("t4_ovf_rejects", n_r2 - s_r2, 3);
    chk("t4_ovf_flag", overflow2, 1);
    repeat (30) @(negedge clk);
    chk("t4_ovf_sticky", overflow2, 1);
    // T5 accept_en dropped with coins in flight
    snap();
    dollar_raw = 1'b1; half_raw = 1'b1; repeat (8) @(negedge clk);
    accept_en = 1'b0; repeat (2) @(negedge clk);
    dollar_raw = 1'b0; half_raw = 1'b0; repeat (12) @(negedge clk);
    dollar_raw = 1'b1; repeat (8) @(negedge clk);
    dollar_raw = 1'b0; repeat (15) @(negedge clk);
    chk("t5_dollar", n_d - s_d, 1);
    chk("t5_half", n_h - s_h, 1);
    chk("t5_reject", n_r - s_r, 1);
    chk("t5_overflow", overflow, 0);
    accept_en = 1'b1;
    // T6 reset during pulse
    dollar_raw = 1'b1; repeat (8) @(negedge clk);
    chk("t6_pulse_high", one_dollar, 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_drop", one_dollar, 0);
    chk("t6_ovf_cleared", overflow2, 0);
    dollar_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap();
    repeat (15) @(negedge clk);
    chk("t6_no_stale_dollar", n_d - s_d, 0);
    chk("t6_no_stale_half", n_h - s_h, 0);
    chk("t6_no_reject", n_r - s_r, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_overflow2", overflow2, 0);
    chk("never_both", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
